// File: rtl/fixedpoint_pkg.sv
// Shared widths, Q6.9 constants and accumulator FSM states for the fixed-point datapath.
// No logic; no latency; no flow control.
package fixedpoint_pkg;
    localparam int WIDTH_PROD = 32;
    localparam int WIDTH_ACC  = 40;
    localparam int WIDTH_OUT  = 16;
    localparam int FRAC_SHIFT = 9;
    localparam int MAX_TERMS  = 256;

    localparam logic [15:0] Q_ONE = 16'h0200;
    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } acc_state_e;
endpackage

// File: rtl/fixedpoint_requantize.sv
// Round-half-up, arithmetic right shift and saturate a wide signed sum to the output format.
// Purely combinational; no backpressure.
module fixedpoint_requantize #(
    parameter int WIDTH_IN   = 41,
    parameter int WIDTH_OUT  = 16,
    parameter int FRAC_SHIFT = 9
) (
    input  logic [WIDTH_IN-1:0]  sum,
    output logic [WIDTH_OUT-1:0] data,
    output logic                 sat
);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int WR = WIDTH_IN + 1;
    localparam logic [WR-1:0] HALF = {{(WR-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

    logic signed [WR-1:0] biased;
    logic signed [WR-1:0] shifted;
    logic [WR-WIDTH_OUT:0] upper;

    always_comb begin
        biased  = $signed({sum[WIDTH_IN-1], sum}) + $signed(HALF);
        shifted = biased >>> FRAC_SHIFT;
        upper   = shifted[WR-1:WIDTH_OUT-1];
        sat     = 1'b0;
        data    = shifted[WIDTH_OUT-1:0];
        // Result fits only if every bit above the output sign bit matches it.
        if (!((&upper) || !(|upper))) begin
            sat  = 1'b1;
            data = shifted[WR-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                 : {1'b0, {(WIDTH_OUT-1){1'b1}}};
        end
    end
endmodule

// File: rtl/fixedpoint_accumulator.sv
// Sums last-terminated groups of signed products and emits one requantised Q6.9 result per group.
// Latency: result valid the cycle after the last beat; input stalls (ready_o=0) while a result waits.
// Backpressure: result held stable until ready_i; one idle cycle before the next group is accepted.
module fixedpoint_accumulator
    import fixedpoint_pkg::*;
#(
    parameter int WIDTH_PROD = fixedpoint_pkg::WIDTH_PROD,
    parameter int WIDTH_ACC  = fixedpoint_pkg::WIDTH_ACC,
    parameter int WIDTH_OUT  = fixedpoint_pkg::WIDTH_OUT,
    parameter int FRAC_SHIFT = fixedpoint_pkg::FRAC_SHIFT,
    parameter int MAX_TERMS  = fixedpoint_pkg::MAX_TERMS
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [WIDTH_PROD-1:0]          data_i,
    input  logic                           last_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [WIDTH_OUT-1:0]           data_o,
    output logic                           sat_o,
    output logic [$clog2(MAX_TERMS+1)-1:0] count_o
);
    localparam int CW = $clog2(MAX_TERMS + 1);
    localparam int SW = WIDTH_ACC + 1;
    localparam logic [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
    localparam logic [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};

    acc_state_e state, state_nxt;

    logic [WIDTH_ACC-1:0] acc;
    logic [WIDTH_ACC-1:0] acc_sat;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_inc;
    logic                 sticky;
    logic [SW-1:0]        sum;
    logic                 acc_ovf;
    logic                 accept;
    logic [WIDTH_OUT-1:0] q_data;
    logic                 q_sat;

    always_comb begin
        sum       = {acc[WIDTH_ACC-1], acc}
                  + {{(SW-WIDTH_PROD){data_i[WIDTH_PROD-1]}}, data_i};
        acc_ovf   = sum[SW-1] != sum[SW-2];
        acc_sat   = acc_ovf ? (sum[SW-1] ? ACC_MIN : ACC_MAX) : sum[WIDTH_ACC-1:0];
        count_inc = (count == CW'(MAX_TERMS)) ? count : count + 1'b1;
    end

    fixedpoint_requantize #(
        .WIDTH_IN   (SW),
        .WIDTH_OUT  (WIDTH_OUT),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_requantize (
        .sum  (sum),
        .data (q_data),
        .sat  (q_sat)
    );

    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        accept    = 1'b0;
        case (state)
            S_ACC: begin
                ready_o = 1'b1;
                // A beat arriving together with clear is discarded.
                accept  = valid_i && !clear_i;
                if (accept && last_i) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= S_ACC;
            acc     <= '0;
            count   <= '0;
            sticky  <= 1'b0;
            data_o  <= '0;
            sat_o   <= 1'b0;
            count_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_ACC && clear_i) begin
                acc    <= '0;
                count  <= '0;
                sticky <= 1'b0;
            end else if (accept && last_i) begin
                data_o  <= q_data;
                sat_o   <= q_sat | sticky;
                count_o <= count_inc;
                acc     <= '0;
                count   <= '0;
                sticky  <= 1'b0;
            end else if (accept) begin
                acc    <= acc_sat;
                count  <= count_inc;
                sticky <= sticky | acc_ovf;
            end
        end
    end
endmodule
